// File: rtl/mem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_rmw_ctrl
// Brief    : Front-end for a 1R1W memory that has no write byte mask.
//            Partial-mask writes become a read followed by a merged write
//            (one MERGE cycle); full-mask writes and reads pass through.
//            Reads may be accepted during MERGE; a read of the address being
//            merged is served from the merged word instead of stale memory.
// Options  : MEM_RMW_CTRL_STATS_EN - saturating 16-bit count of completed
//            merges on rmw_count (tied to 0 when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module mem_rmw_ctrl #(
  parameter int DEPTH      = 48,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_GRAN  = 8,
  parameter int MASK_WIDTH = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [MASK_WIDTH-1:0] req_mask,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] R0_addr,
  output logic                  R0_en,
  input  logic [DATA_WIDTH-1:0] R0_data,
  output logic [ADDR_WIDTH-1:0] W0_addr,
  output logic                  W0_en,
  output logic [DATA_WIDTH-1:0] W0_data,
  output logic [15:0]           rmw_count
);

  localparam logic [ADDR_WIDTH:0] c_depth_ext = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic [MASK_WIDTH-1:0] mask_q,     mask_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic                  rsp_byp_q,  rsp_byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_r0_en;
  logic                  w_w0_en;
  logic [DATA_WIDTH-1:0] w_merged;

  // Lane merge: masked lanes from the latched write, others from memory
  for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_lane
    assign w_merged[i*MASK_GRAN +: MASK_GRAN] =
      mask_q[i] ? data_q[i*MASK_GRAN +: MASK_GRAN] : R0_data[i*MASK_GRAN +: MASK_GRAN];
  end

  assign req_ready  = (state_q == IDLE) | ((state_q == MERGE) & ~req_write);
  assign w_accept   = req_valid & req_ready;
  assign w_in_range = {1'b0, req_addr} < c_depth_ext;

  // Memory enables are forced low while reset is asserted
  assign R0_en     = w_r0_en & ~reset;
  assign W0_en     = w_w0_en & ~reset;
  assign rsp_valid = rsp_valid_q;

  // Next-state, memory-port drive and response bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rsp_valid_d = 1'b0;
    rsp_zero_d  = 1'b0;
    rsp_byp_d   = 1'b0;
    byp_data_d  = byp_data_q;
    w_r0_en     = 1'b0;
    w_w0_en     = 1'b0;
    R0_addr     = req_addr;
    W0_addr     = req_addr;
    W0_data     = req_data;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (!req_write) begin
            rsp_valid_d = 1'b1;
            rsp_zero_d  = ~w_in_range;
            w_r0_en     = w_in_range;
          end else if (w_in_range) begin
            if (&req_mask) begin
              w_w0_en = 1'b1;
            end else if (|req_mask) begin
              // Fetch the old word now; merge and write it next cycle
              w_r0_en = 1'b1;
              addr_d  = req_addr;
              data_d  = req_data;
              mask_d  = req_mask;
              state_d = MERGE;
            end
          end
        end
      end
      MERGE: begin
        w_w0_en = 1'b1;
        W0_addr = addr_q;
        W0_data = w_merged;
        state_d = IDLE;
        // Only reads can be accepted here, so the R0 port is free
        if (w_accept) begin
          rsp_valid_d = 1'b1;
          rsp_zero_d  = ~w_in_range;
          w_r0_en     = w_in_range;
          if (w_in_range && (req_addr == addr_q)) begin
            // Memory would return the pre-merge word; serve the merged one
            rsp_byp_d  = 1'b1;
            byp_data_d = w_merged;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data: bypass word, zero for out-of-range, else memory output
  always_comb begin
    rsp_data = '0;
    if (rsp_valid_q) begin
      if (rsp_byp_q) begin
        rsp_data = byp_data_q;
      end else if (!rsp_zero_q) begin
        rsp_data = R0_data;
      end
    end
  end

  // Controller state and pending-operation registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_byp_q   <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_byp_q   <= rsp_byp_d;
      byp_data_q  <= byp_data_d;
    end
  end

`ifdef MEM_RMW_CTRL_STATS_EN
  logic [15:0] rmw_count_q, rmw_count_d;

  // Saturating count of merge cycles that completed without reset
  always_comb begin
    rmw_count_d = rmw_count_q;
    if ((state_q == MERGE) && (rmw_count_q != 16'hFFFF)) begin
      rmw_count_d = rmw_count_q + 16'd1;
    end
  end

  // Merge counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rmw_count_q <= 16'd0;
    end else begin
      rmw_count_q <= rmw_count_d;
    end
  end

  assign rmw_count = rmw_count_q;
`else
  assign rmw_count = 16'd0;
`endif

endmodule
`default_nettype wire
